// File: rtl/simd_addsub_mc.sv
// Multi-cycle SIMD add/subtract: carries ripple one segment per cycle.
// Optional per-element saturation is built when SIMD_ADDSUB_SAT_EN is defined.
module simd_addsub_mc #(
    parameter int SEG_W  = 8,
    parameter int NSEG   = 8,
    parameter int WW_MAX = 3,
    localparam int DATA_W = SEG_W * NSEG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [1:0]        ww,
    input  logic              sub,
    input  logic              sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [NSEG-1:0]   carry,
    output logic [NSEG-1:0]   ovf
);

    localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] a_q, b_q, result_q, res_d;
    logic [NSEG-1:0]   c_q, co_d, cin;
    logic [NSEG-1:0]   carry_q, carry_d, ovf_q, ovf_d;
    logic [1:0]        ww_q, ww_c;
    logic              sub_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        nm1;
    logic              accept;
    logic [SEG_W-1:0]  sum_s [NSEG];
    logic [SEG_W-1:0]  seg;
    logic              lsb, sa_e, ov_e, co_e;

`ifdef SIMD_ADDSUB_SAT_EN
    logic sat_q;
`else
    logic sat_unused;
    assign sat_unused = sat;
`endif

    assign ww_c      = (ww > 2'(WW_MAX)) ? 2'(WW_MAX) : ww;
    assign nm1       = (4'd1 << ww_q) - 4'd1;
    assign cin       = c_q >> 1;
    assign in_ready  = (state_q == IDLE) |
                       ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

    // Segment 0 is most significant; an element's MS segment
    // fixes its sign and carry, so walk segments in that order.
    always_comb begin
        co_d    = '0;
        carry_d = '0;
        ovf_d   = '0;
        res_d   = '0;
        seg     = '0;
        lsb     = 1'b0;
        sa_e    = 1'b0;
        ov_e    = 1'b0;
        co_e    = 1'b0;
        for (int s = 0; s < NSEG; s++) begin
            sum_s[s] = '0;
        end
        for (int s = 0; s < NSEG; s++) begin
            lsb = (4'(s) & nm1) == nm1;
            {co_d[s], sum_s[s]} =
                {1'b0, a_q[DATA_W-1-s*SEG_W -: SEG_W]} +
                {1'b0, b_q[DATA_W-1-s*SEG_W -: SEG_W]} +
                {{SEG_W{1'b0}}, lsb ? sub_q : cin[s]};
            if ((4'(s) & nm1) == 4'd0) begin
                sa_e = a_q[DATA_W-1-s*SEG_W];
                ov_e = (sa_e == b_q[DATA_W-1-s*SEG_W]) &&
                       (sum_s[s][SEG_W-1] != sa_e);
                co_e = co_d[s];
            end
            seg = sum_s[s];
`ifdef SIMD_ADDSUB_SAT_EN
            if (sat_q && ov_e) begin
                seg = ((4'(s) & nm1) == 4'd0)
                    ? {sa_e, {(SEG_W-1){~sa_e}}}
                    : {SEG_W{~sa_e}};
            end
`endif
            res_d[DATA_W-1-s*SEG_W -: SEG_W] = seg;
            if (lsb) begin
                carry_d[NSEG-1-s] = co_e;
                ovf_d[NSEG-1-s]   = ov_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ww_q     <= '0;
            sub_q    <= 1'b0;
            c_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= '0;
            ovf_q    <= '0;
`ifdef SIMD_ADDSUB_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                CALC: begin
                    c_q   <= co_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == nm1[CNT_W-1:0]) begin
                        result_q <= res_d;
                        carry_q  <= carry_d;
                        ovf_q    <= ovf_d;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready && !in_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (accept) begin
                a_q     <= op1;
                b_q     <= op2 ^ {DATA_W{sub}};
                ww_q    <= ww_c;
                sub_q   <= sub;
                c_q     <= '0;
                cnt_q   <= '0;
                state_q <= CALC;
`ifdef SIMD_ADDSUB_SAT_EN
                sat_q   <= sat;
`endif
            end
        end
    end

endmodule

// File: tb/tb_simd_addsub_mc.sv
// Scoreboard bench for simd_addsub_mc: element-level arithmetic model,
// decoupled driver / consumer / monitor processes.
`timescale 1ns/1ps
module tb_simd_addsub_mc;

    localparam int SEG_W  = 8;
    localparam int NSEG   = 8;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] op1, op2, result;
    logic [1:0]        ww;
    logic              sub, sat;
    logic              out_valid, out_ready;
    logic [NSEG-1:0]   carry, ovf;

    simd_addsub_mc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .ww        (ww),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit stall     = 1'b0;
    bit rnd_ready = 1'b0;

    typedef struct {
        logic [63:0] r;
        logic [7:0]  c;
        logic [7:0]  o;
        int          due;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, b,
                                   input logic [1:0] w,
                                   input logic s, st);
        exp_t e;
        int n, ew, ne, sh, ls;
        logic [64:0] mask, ea, eb, sm, r;
        logic c, o, sa, sb, sr, sat_on;
        sat_on = st;
`ifndef SIMD_ADDSUB_SAT_EN
        sat_on = 1'b0;
`endif
        n  = 1 << w;
        ew = SEG_W * n;
        ne = NSEG / n;
        e.r = '0; e.c = '0; e.o = '0; e.due = 0;
        mask = (65'd1 << ew) - 65'd1;
        for (int k = 0; k < ne; k++) begin
            sh = (ne - 1 - k) * ew;
            ea = ({1'b0, a} >> sh) & mask;
            eb = ({1'b0, (s ? ~b : b)} >> sh) & mask;
            sm = ea + eb + {64'd0, s};
            c  = sm[ew];
            r  = sm & mask;
            sa = ea[ew-1];
            sb = eb[ew-1];
            sr = r[ew-1];
            o  = (sa == sb) && (sr != sa);
            if (sat_on && o) r = sa ? (65'd1 << (ew - 1)) : (mask >> 1);
            e.r = e.r | 64'(r << sh);
            ls = (k + 1) * n - 1;
            e.c[NSEG-1-ls] = c;
            e.o[NSEG-1-ls] = o;
        end
        return e;
    endfunction

    task automatic issue(input logic [63:0] a, b, input logic [1:0] w,
                         input logic s, st, output int acc);
        acc = -1;
        @(negedge clk);
        op1 = a; op2 = b; ww = w; sub = s; sat = st; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #4;
            if (in_ready) acc = cyc;
            @(posedge clk);
            if (acc >= 0) break;
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        op1 = {$urandom, $urandom};
        op2 = {$urandom, $urandom};
        ww  = 2'($urandom_range(0, 3));
        sub = 1'($urandom_range(0, 1));
        if (acc < 0) begin
            checks++; failures++;
            $display("FAIL accept_timeout: in_ready never seen");
        end
    endtask

    task automatic run(input logic [63:0] a, b, input logic [1:0] w,
                       input logic s, st, input bit lit,
                       input logic [63:0] lr, input logic [7:0] lc, lo);
        int acc;
        exp_t e;
        issue(a, b, w, s, st, acc);
        if (acc >= 0) begin
            e = model(a, b, w, s, st);
            if (lit) begin
                e.r = lr; e.c = lc; e.o = lo;
            end
            e.due = acc + 1 + (1 << w);
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sbq.size() != 0; k++) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain: %0d results outstanding", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (stall)          out_ready = 1'b0;
            else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            else                out_ready = 1'b1;
        end
    end

    initial begin
        bit seen = 1'b0;
        logic [63:0] snap_r;
        logic [15:0] snap_f;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                seen = 1'b0;
                continue;
            end
            if (!out_valid && sbq.size() != 0 && cyc > sbq[0].due + 2) begin
                checks++; failures++;
                $display("FAIL result_timeout: no out_valid, due cycle %0d",
                         sbq[0].due);
                void'(sbq.pop_front());
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out: result %h", result);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 64'(cyc), 64'(sbq[0].due));
                        snap_r = result;
                        snap_f = {carry, ovf};
                    end else begin
                        chk("stable_result", result, snap_r);
                        chk("stable_flags", 64'({carry, ovf}), 64'(snap_f));
                    end
                    chk("in_ready_done", 64'(in_ready), 64'(out_ready));
                    if (out_ready) begin
                        chk("result", result, sbq[0].r);
                        chk("carry", 64'(carry), 64'(sbq[0].c));
                        chk("ovf", 64'(ovf), 64'(sbq[0].o));
                        void'(sbq.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int acc;
        logic [63:0] a, b;
        reset = 1'b1; in_valid = 1'b0;
        op1 = '0; op2 = '0; ww = '0; sub = 1'b0; sat = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'({carry, ovf}), 64'd0);
        reset = 1'b0;

        run(64'h00FF_0000_0000_0001, 64'h0001_0000_0000_0001, 2'd0, 0, 0,
            1, 64'h0000_0000_0000_0002, 8'b0100_0000, 8'h00);
        run(64'h0000_0000_FFFF_FFFF, 64'd1, 2'd3, 0, 0,
            1, 64'h0000_0001_0000_0000, 8'h00, 8'h00);
        run(64'h0000_0005_0000_0005, 64'h0000_0007_0000_0007, 2'd2, 1, 0,
            1, 64'hFFFF_FFFE_FFFF_FFFE, 8'h00, 8'h00);
        run(64'h8000_0000_8000_0000, 64'h0000_0001_0000_0001, 2'd2, 1, 0,
            1, 64'h7FFF_FFFF_7FFF_FFFF, 8'h11, 8'h11);
`ifdef SIMD_ADDSUB_SAT_EN
        run(64'h7F7F_7F7F_7F7F_7F7F, 64'h0101_0101_0101_0101, 2'd0, 0, 1,
            1, 64'h7F7F_7F7F_7F7F_7F7F, 8'h00, 8'hFF);
`else
        run(64'h7F7F_7F7F_7F7F_7F7F, 64'h0101_0101_0101_0101, 2'd0, 0, 1,
            1, 64'h8080_8080_8080_8080, 8'h00, 8'hFF);
`endif
        drain();

        stall = 1'b1;
        run({$urandom, $urandom}, {$urandom, $urandom}, 2'd1, 0, 0,
            0, '0, '0, '0);
        fork
            run({$urandom, $urandom}, {$urandom, $urandom}, 2'd0, 1, 0,
                0, '0, '0, '0);
            begin
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                repeat (5) @(negedge clk);
                stall = 1'b0;
            end
        join
        drain();

        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2'd3, 0, 0,
              acc);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd3, 0, 0, 0, '0, '0, '0);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) a = 64'h7F7F_7F7F_7FFF_FFFF;
            if ($urandom_range(0, 4) == 0) b = 64'h8080_8080_8000_0001;
            if ($urandom_range(0, 6) == 0) b = '1;
            run(a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0, '0, '0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
